// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory, buffers returned words in a small queue, and hands
// them to decode over a valid/ready handshake. Execute-stage redirects
// flush the queue and restart fetch at the target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic [6:0]  op
);

  localparam int          PW      = (DEPTH == 4) ? 2 : 1;
  localparam logic [3:0]  DEPTH_W = 4'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q,   req_pc_d;
  logic [2:0]    count_q,    count_d;
  logic          inflight_q, inflight_d;
  logic          kill_q,     kill_d;
  logic [PW-1:0] head_q,     head_d;
  logic [PW-1:0] tail_q,     tail_d;
  logic [31:0]   pc_mem_q  [DEPTH];
  logic [31:0]   pc_mem_d  [DEPTH];
  logic [31:0]   ins_mem_q [DEPTH];
  logic [31:0]   ins_mem_d [DEPTH];

  logic       pop;
  logic       wr;
  logic [3:0] occ;

  // Handshake, issue decision and head presentation.
  // Occupancy counts the in-flight request so a response always has a slot.
  always_comb begin
    instr_valid    = (count_q != 3'd0);
    pop            = instr_valid & instr_ready;
    wr             = inflight_q & ~kill_q & ~redirect;
    occ            = {1'b0, count_q} + {3'b000, inflight_q} - {3'b000, pop};
    imem_req       = ~rst & ~redirect & (occ < DEPTH_W);
    imem_addr      = fetch_pc_q;
    instr          = instr_valid ? ins_mem_q[head_q] : NOP;
    instr_pc       = pc_mem_q[head_q];
    instr_pc_plus4 = instr_pc + 32'd4;
    op             = instr[6:0];
  end

  // Next-state: PC advance/redirect, queue write/pop, flush on redirect.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    // A request issued alongside a redirect would belong to the old path;
    // issue is already blocked then, so this stays low but guards the invariant.
    kill_d     = redirect & imem_req;
    head_d     = head_q + PW'(pop);
    tail_d     = tail_q + PW'(wr);
    count_d    = count_q + 3'(wr) - 3'(pop);
    pc_mem_d   = pc_mem_q;
    ins_mem_d  = ins_mem_q;

    if (imem_req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end
    if (wr) begin
      pc_mem_d[tail_q]  = req_pc_q;
      ins_mem_d[tail_q] = imem_rdata;
    end
    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      count_d    = 3'd0;
      head_d     = '0;
      tail_d     = '0;
    end
  end

  // State registers with synchronous reset; storage resets to {0, NOP}.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'd0;
      count_q    <= 3'd0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= 32'd0;
        ins_mem_q[i] <= NOP;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pc_mem_q   <= pc_mem_d;
      ins_mem_q  <= ins_mem_d;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of `main_decoder`. It owns the program counter and issues word reads to a synchronous instruction memory. Returned instructions are buffered in a small queue and presented to decode with a valid/ready handshake. Its `op` output is the opcode field that drives `main_decoder`, and it accepts the PCSrc/PCTarget redirect from the execute stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: instruction queue entries; legal values are 2 or 4.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req` out 1: read request this cycle.
- `imem_addr` out 32: byte address of the request; always word aligned.
- `imem_rdata` in 32: read data, valid exactly one cycle after the cycle `imem_req`=1.
- `redirect` in 1: PCSrc (Branch&Zero | Jump); this cycle's fetch path is redirected.
- `redirect_pc` in 32: PCTarget; bits [1:0] are ignored and forced to 0.
- `instr_valid` out 1: the queue head holds a valid instruction.
- `instr_ready` in 1: decode accepts the head this cycle.
- `instr` out 32: head instruction; 32'h0000_0013 (NOP) when `instr_valid`=0.
- `instr_pc` out 32: PC of the head instruction.
- `instr_pc_plus4` out 32: `instr_pc` + 4, with modulo-2^32 wrap.
- `op` out 7: `instr[6:0]`, feeding `main_decoder.op`.

## Operation
- State:
  - `fetch_pc` register.
  - Queue of DEPTH {pc, instr} entries with `count` 0..DEPTH.
  - `inflight` flag: a request was issued last cycle.
  - `kill` flag: the in-flight response must be discarded.
- `pop` = `instr_valid` & `instr_ready`. The head advances at the clock edge.
- Issue condition: `imem_req` = !`rst` & !`redirect` & (`count` + `inflight` − `pop` < DEPTH). This is a combinational path from `instr_ready`.
- On issue: `imem_addr` = `fetch_pc`; `fetch_pc` ← `fetch_pc` + 4, with wrap from 32'hFFFF_FFFC to 0.
- Response cycle: if `inflight` & !`kill` & !`redirect`, {pc of request, `imem_rdata`} is written to the queue tail. Otherwise the response is dropped.
- Redirect cycle:
  - Queue flushed (`count` ← 0).
  - Any response arriving this cycle is dropped.
  - `fetch_pc` ← {`redirect_pc`[31:2], 2'b00}.
  - No issue this cycle.
  - A simultaneous `pop` completes normally; the head, i.e. the branch or jump itself, is consumed.
- Back-to-back redirects: the last one wins.
- Full queue: no issue. Since the issue condition counts in-flight requests, the queue never overflows.
- Empty queue: `instr_valid`=0, `instr`=NOP, `op`=7'b0010011.
- Simultaneous write and pop: the count is unchanged.

## Timing
- Reset, checked at the edge while `rst`=1:
  - `fetch_pc`←`RESET_PC`; `count`, `inflight`, `kill`←0.
  - Head storage ← {0, NOP}.
  - During `rst`: `imem_req`=0, `instr_valid`=0, `instr`=NOP, `instr_pc`=0, `instr_pc_plus4`=4.
- First cycle with `rst`=0 (cycle 0): `imem_req`=1, `imem_addr`=`RESET_PC`.
- Fetch latency is two cycles: request in cycle N, data at cycle N+1, `instr_valid` at N+2 (no bypass).
- Steady state with `instr_ready`=1: one instruction per cycle, with consecutive PCs.
- Redirect in cycle R:
  - `instr_valid`=0 from R+1.
  - Request to `redirect_pc` in R+1.
  - New instruction valid in R+3.
- Reset mid-operation: the queue is flushed and the pending response is dropped. The sequence restarts as in the cold-start case.
- Outputs hold stable while `instr_valid`=1 and `instr_ready`=0.

## Test plan
- **Cold start:** imem holds words at PCs 0,4,8 with opcodes 0000011, 0100011, 0110011; `rst` high 2 cycles, then low; `instr_ready`=1. Required:
  - `imem_addr` = 0,4,8 from cycle 0.
  - `instr_valid` first high at cycle 2 with `instr_pc`=0 and `op`=0000011.
  - `op` = 0100011, then 0110011, on consecutive cycles.
- **Back-pressure:** `instr_ready`=0 from cycle 2. Required:
  - Exactly DEPTH=2 entries are buffered.
  - `imem_req` drops after the 2nd issue.
  - Outputs hold PC 0.
  - On release, PCs 0,4,8,… are delivered with no gaps or duplicates.
- **Redirect:** `redirect`=1, `redirect_pc`=32'h0000_0103 while the queue is full and a request is in flight. Required:
  - Queue flushed; the stale response is dropped.
  - Next `imem_addr`=32'h100.
  - `instr_valid` returns 2 cycles after that request with `instr_pc`=32'h100.
- **Simultaneous redirect and pop:** the head is a 1100011 branch. Required:
  - The branch is consumed exactly once.
  - No younger instruction is ever presented.
- **Reset mid-stream:** `rst`=1 for one cycle during steady fetch. Required:
  - Next cycle `instr_valid`=0 and `op`=0010011.
  - Fetch restarts at `RESET_PC`.
- **Wrap-around:** `redirect_pc`=32'hFFFF_FFFC. Required:
  - Fetch addresses are FFFF_FFFC, then 0.
  - `instr_pc_plus4`=0 for the first instruction.
